// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - multi-cycle RV32M multiply/divide execute unit
// Iterative shift-add multiply and restoring divide, UNROLL bits per CALC cycle.
module ex_muldiv #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            hold_flag_o,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            rd_wen_o
);

    localparam int STEPS = XLEN / UNROLL;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q;
    logic            neg_q;
    logic [XLEN-1:0] hi_q, lo_q, opd_q, res_q;

    logic            is_div, sgn1, sgn2, neg1, neg2, neg_res;
    logic [XLEN-1:0] mag1, mag2, special_res;
    logic            div_zero, div_ovf, special, accept, last_step;

    always_comb begin
        is_div   = funct3_i[2];
        sgn1     = is_div ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
        sgn2     = is_div ? ~funct3_i[0] : ~funct3_i[1];
        neg1     = sgn1 & op1_i[XLEN-1];
        neg2     = sgn2 & op2_i[XLEN-1];
        mag1     = neg1 ? -op1_i : op1_i;
        mag2     = neg2 ? -op2_i : op2_i;
        // Remainder follows the dividend sign; everything else uses the sign product.
        neg_res  = (is_div & funct3_i[1]) ? neg1 : (neg1 ^ neg2);
        div_zero = is_div & (op2_i == '0);
        div_ovf  = is_div & ~funct3_i[0] & (op1_i == {1'b1, {(XLEN-1){1'b0}}}) & (op2_i == '1);
        special  = div_zero | div_ovf;
        if (div_zero) begin
            special_res = funct3_i[1] ? op1_i : '1;
        end else begin
            special_res = funct3_i[1] ? '0 : op1_i;
        end
        accept    = (state_q == S_IDLE) & start_i & ~flush_i;
        last_step = (cnt_q == CW'(STEPS - 1));
    end

    // One datapath iteration chain: hi/lo hold partial product or remainder/quotient.
    logic [XLEN-1:0] hi_n, lo_n;
    logic [XLEN:0]   trial, sum;

    always_comb begin
        hi_n  = hi_q;
        lo_n  = lo_q;
        trial = '0;
        sum   = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (f3_q[2]) begin
                trial = {hi_n, lo_n[XLEN-1]};
                lo_n  = {lo_n[XLEN-2:0], 1'b0};
                if (trial >= {1'b0, opd_q}) begin
                    trial   = trial - {1'b0, opd_q};
                    lo_n[0] = 1'b1;
                end
                hi_n = trial[XLEN-1:0];
            end else begin
                sum          = {1'b0, hi_n} + (lo_n[0] ? {1'b0, opd_q} : '0);
                {hi_n, lo_n} = {sum, lo_n[XLEN-1:1]};
            end
        end
    end

    logic [2*XLEN-1:0] prod, prod_f;
    logic [XLEN-1:0]   div_v, div_f, res_n;

    always_comb begin
        prod   = {hi_n, lo_n};
        prod_f = neg_q ? -prod : prod;
        div_v  = f3_q[1] ? hi_n : lo_n;
        div_f  = neg_q ? -div_v : div_v;
        if (f3_q[2]) begin
            res_n = div_f;
        end else if (f3_q[1:0] == 2'b00) begin
            res_n = prod_f[XLEN-1:0];
        end else begin
            res_n = prod_f[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = special ? S_DONE : S_CALC;
            S_CALC: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (last_step) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            opd_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                f3_q  <= funct3_i;
                rd_q  <= rd_addr_i;
                neg_q <= neg_res;
                cnt_q <= '0;
                hi_q  <= '0;
                lo_q  <= mag1;
                opd_q <= mag2;
                if (special) begin
                    res_q <= special_res;
                end
            end else if (state_q == S_CALC) begin
                hi_q  <= hi_n;
                lo_q  <= lo_n;
                cnt_q <= cnt_q + CW'(1);
                if (last_step) begin
                    res_q <= res_n;
                end
            end
        end
    end

    // Stall is combinational so it covers the accept cycle; released in DONE.
    assign hold_flag_o = (accept & ~special) | ((state_q == S_CALC) & ~flush_i);
    assign busy_o      = (state_q != S_IDLE);
    assign rd_wen_o    = (state_q == S_DONE);
    assign rd_data_o   = rd_wen_o ? res_q : '0;
    assign rd_addr_o   = rd_wen_o ? rd_q : '0;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - directed self-checking bench for ex_muldiv
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst_n, start, flush;
    logic [2:0]  funct3;
    logic [31:0] op1, op2;
    logic [4:0]  rd_addr;
    logic        busy, hold, wen, busy4, hold4, wen4;
    logic [4:0]  raddr, raddr4;
    logic [31:0] rdata, rdata4;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    always #5 clk = ~clk;

    ex_muldiv #(.XLEN(32), .UNROLL(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .funct3_i(funct3), .op1_i(op1), .op2_i(op2),
        .rd_addr_i(rd_addr), .flush_i(flush), .busy_o(busy), .hold_flag_o(hold),
        .rd_addr_o(raddr), .rd_data_o(rdata), .rd_wen_o(wen)
    );

    ex_muldiv #(.XLEN(32), .UNROLL(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .funct3_i(funct3), .op1_i(op1), .op2_i(op2),
        .rd_addr_i(rd_addr), .flush_i(flush), .busy_o(busy4), .hold_flag_o(hold4),
        .rd_addr_o(raddr4), .rd_data_o(rdata4), .rd_wen_o(wen4)
    );

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int lat, output logic [31:0] data,
                         output logic [4:0] addr, output int holds, output int wens,
                         output int lat4, output logic [31:0] data4);
        lat = -1; lat4 = -1; data = '0; data4 = '0; addr = '0; holds = 0; wens = 0;
        @(negedge clk);
        start = 1'b1; funct3 = f; op1 = a; op2 = b; rd_addr = rd;
        #1;
        if (hold) holds++;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (hold) holds++;
            if (wen) begin
                wens++;
                if (lat < 0) begin lat = k; data = rdata; addr = raddr; end
            end
            if (wen4 && lat4 < 0) begin lat4 = k; data4 = rdata4; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; op1 = '0; op2 = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({busy, hold, wen} !== 3'b000) $display("FAIL reset_ctrl got %b want 000", {busy, hold, wen});
        else pass_cnt++;
        total_cnt++;
        if ({raddr, rdata} !== 37'd0) $display("FAIL reset_data got %h/%h want 0/0", raddr, rdata);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_table(input string name, input logic [2:0] f[], input logic [31:0] a[],
                              input logic [31:0] b[], input logic [31:0] exp[], input int exp_lat,
                              input int exp_holds);
        int lat, holds, wens, lat4;
        logic [31:0] data, data4;
        logic [4:0] addr;
        for (int i = 0; i < f.size(); i++) begin
            do_op(f[i], a[i], b[i], 5'(i + 3), lat, data, addr, holds, wens, lat4, data4);
            total_cnt++;
            if (data !== exp[i]) $display("FAIL %s_data[%0d] got %h want %h", name, i, data, exp[i]);
            else pass_cnt++;
            total_cnt++;
            if (lat !== exp_lat) $display("FAIL %s_lat[%0d] got %0d want %0d", name, i, lat, exp_lat);
            else pass_cnt++;
            total_cnt++;
            if (holds !== exp_holds) $display("FAIL %s_hold[%0d] got %0d want %0d", name, i, holds, exp_holds);
            else pass_cnt++;
            total_cnt++;
            if (wens !== 1 || addr !== 5'(i + 3))
                $display("FAIL %s_wb[%0d] got %0d/%0d want 1/%0d", name, i, wens, addr, i + 3);
            else pass_cnt++;
        end
    endtask

    task automatic test_mul();
        test_table("mul",
            '{3'b000, 3'b001, 3'b011, 3'b010, 3'b000, 3'b001},
            '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF},
            '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h10, 32'd2},
            '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h2345_6780, 32'hFFFF_FFFF},
            33, 33);
    endtask

    task automatic test_div();
        test_table("div",
            '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110},
            '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'd7},
            '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE},
            '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFD, 32'd1},
            33, 33);
    endtask

    task automatic test_special();
        test_table("spec",
            '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110},
            '{32'd5, 32'd5, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000},
            '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
            '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0},
            1, 0);
    endtask

    task automatic test_x0_and_unroll();
        int lat, holds, wens, lat4;
        logic [31:0] data, data4;
        logic [4:0] addr;
        do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd0, lat, data, addr, holds, wens, lat4, data4);
        total_cnt++;
        if (wens !== 1 || addr !== 5'd0) $display("FAIL x0_wb got %0d/%0d want 1/0", wens, addr);
        else pass_cnt++;
        total_cnt++;
        if (lat4 !== 9) $display("FAIL unroll4_lat got %0d want 9", lat4);
        else pass_cnt++;
        total_cnt++;
        if (data4 !== 32'hFFFF_FFEB) $display("FAIL unroll4_data got %h want ffffffeb", data4);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        int wens = 0;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; op1 = 32'd9; op2 = 32'd9; rd_addr = 5'd4;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        total_cnt++;
        if ({busy, hold} !== 2'b10) $display("FAIL flush_hold got %b want 10", {busy, hold});
        else pass_cnt++;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL flush_idle got %b want 0", busy);
        else pass_cnt++;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (wen) wens++;
        end
        total_cnt++;
        if (wens !== 0) $display("FAIL flush_nowb got %0d want 0", wens);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int wens = 0;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; op1 = 32'd9; op2 = 32'd9; rd_addr = 5'd4;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        total_cnt++;
        if ({busy, hold} !== 2'b11) $display("FAIL rstmid_pre got %b want 11", {busy, hold});
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({busy, hold, wen, raddr, rdata} !== 40'd0)
            $display("FAIL rstmid_out got %b/%h want 0/0", {busy, hold, wen, raddr}, rdata);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (wen) wens++;
        end
        total_cnt++;
        if (wens !== 0) $display("FAIL rstmid_nowb got %0d want 0", wens);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int first = -1, second = -1, wens_early = 0;
        logic b34 = 1'b1, h34 = 1'b0;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; op1 = 32'd100; op2 = 32'd7; rd_addr = 5'd9;
        @(posedge clk);
        for (int k = 1; k <= 67; k++) begin
            @(negedge clk);
            if (k == 34) begin b34 = busy; h34 = hold; end
            if (wen) begin
                if (k <= 66) wens_early++;
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
        end
        start = 1'b0;
        total_cnt++;
        if (first !== 33 || wens_early !== 1)
            $display("FAIL b2b_first got %0d/%0d want 33/1", first, wens_early);
        else pass_cnt++;
        total_cnt++;
        if ({b34, h34} !== 2'b01) $display("FAIL b2b_reaccept got %b want 01", {b34, h34});
        else pass_cnt++;
        total_cnt++;
        if (second !== 67) $display("FAIL b2b_second got %0d want 67", second);
        else pass_cnt++;
        repeat (40) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_x0_and_unroll();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
